// File: rtl/lh_digest_hex_serializer.sv
// Turns each captured hash digest into a stream of ASCII hex characters (MSB nibble first).
// Define LH_DIGEST_NEWLINE_EN to append an 8'h0A character to every frame.
module lh_digest_hex_serializer #(
  parameter int DIGEST_W  = 64,
  parameter bit UPPER_HEX = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGEST_W-1:0] digest_char,
  input  logic                digest_ready,
  output logic [7:0]          hex_char,
  output logic                hex_valid,
  input  logic                hex_ready,
  output logic                hex_last,
  output logic                busy,
  output logic                err_overflow,
  input  logic                clr_err
);

  localparam int NCH = DIGEST_W / 4;
  localparam int IW  = $clog2(NCH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

`ifdef LH_DIGEST_NEWLINE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, NL = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;
`endif

  state_t                state_q, state_d;
  logic [DIGEST_W-1:0]   active_q, active_d;
  logic [DIGEST_W-1:0]   pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  xfer;
  logic                  frame_end;
  logic                  overflow;

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
    end
  end

  // The active register shifts left on each transfer, so the outgoing nibble is always the top one.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    err_d       = clr_err ? 1'b0 : err_q;
    overflow    = 1'b0;
    hex_char    = 8'h00;
    hex_last    = 1'b0;
    hex_valid   = (state_q != IDLE);
    xfer        = hex_valid && hex_ready;
`ifdef LH_DIGEST_NEWLINE_EN
    frame_end   = xfer && (state_q == NL);
`else
    frame_end   = xfer && (state_q == SEND) && (idx_q == LAST_IDX);
`endif

    case (state_q)
      IDLE: begin
        if (digest_ready) begin
          active_d = digest_char;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        hex_char = nib_to_ascii(active_q[DIGEST_W-1 -: 4]);
`ifdef LH_DIGEST_NEWLINE_EN
        hex_last = 1'b0;
`else
        hex_last = (idx_q == LAST_IDX);
`endif
        if (xfer && (idx_q != LAST_IDX)) begin
          active_d = active_q << 4;
          idx_d    = idx_q + 1'b1;
        end
`ifdef LH_DIGEST_NEWLINE_EN
        else if (xfer) begin
          idx_d   = idx_q + 1'b1;
          state_d = NL;
        end
`endif
      end
`ifdef LH_DIGEST_NEWLINE_EN
      NL: begin
        hex_char = 8'h0A;
        hex_last = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A frame ending this edge frees a slot, so a simultaneous digest never overflows here.
    if (frame_end) begin
      idx_d = '0;
      if (pend_full_q) begin
        active_d = pend_q;
        state_d  = SEND;
        if (digest_ready)
          pend_d = digest_char;
        else
          pend_full_d = 1'b0;
      end else if (digest_ready) begin
        active_d = digest_char;
        state_d  = SEND;
      end else begin
        state_d = IDLE;
      end
    end else if ((state_q != IDLE) && digest_ready) begin
      if (!pend_full_q) begin
        pend_d      = digest_char;
        pend_full_d = 1'b1;
      end else begin
        overflow = 1'b1;
      end
    end

    if (overflow)
      err_d = 1'b1;
  end

  assign busy         = (state_q != IDLE) || pend_full_q;
  assign err_overflow = err_q;

endmodule
